demux_l2_rx: RTL and testbench

Receive-side lane de-striper for the PHY link. It takes the single byte-wide stream produced by the transmit-side 4:1 lane mux, running at the fast clock (`cclk`, 4× `aclk`). It rebuilds the four 8-bit lanes with their per-lane valids and presents each rebuilt group of four bytes in parallel, with a one-cycle strobe, to the downstream lane FIFOs / clock-crossing logic.

---
 rtl/demux_l2_rx.sv | 135 +++++++++++++
 tb/tb_demux_l2_rx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/demux_l2_rx.sv
// demux_l2_rx: rebuilds four byte lanes from a single striped byte stream.
// A group is aligned on the first valid byte seen while idle. Slots 0..2 are
// held in shadow registers. Slot 3 goes straight to the outputs on the closing edge.
module demux_l2_rx #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 8
) (
    input  logic          cclk,
    input  logic          reset,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out0,
    output logic [DW-1:0] data_out1,
    output logic [DW-1:0] data_out2,
    output logic [DW-1:0] data_out3,
    output logic          valid_out0,
    output logic          valid_out1,
    output logic          valid_out2,
    output logic          valid_out3,
    output logic          out_stb,
    output logic [7:0]    group_cnt
);

    localparam int unsigned SW = $clog2(LANES);
    localparam logic [SW-1:0] LastSlot = SW'(LANES - 1);

    typedef enum logic [0:0] {StIdle, StRecv} state_t;

    state_t             r_state;
    state_t             w_state_d;
    logic [SW-1:0]      r_slot;
    logic [DW-1:0]      r_shadow_d [LANES-1];
    logic [LANES-2:0]   r_shadow_v;
    logic [DW-1:0]      r_data_out [LANES];
    logic [LANES-1:0]   r_valid_out;
    logic               r_out_stb;
    logic [7:0]         r_group_cnt;

    logic [DW-1:0]      w_byte;
    logic               w_close;
    logic               w_any_valid;

    // Invalid bytes are stored as zero so partial groups report clean data.
    assign w_byte      = valid_in ? data_in : '0;
    assign w_any_valid = valid_in | (|r_shadow_v);

    // State register.
    always_ff @(posedge cclk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state and group-close decode.
    always_comb begin
        w_state_d = r_state;
        w_close   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (valid_in) begin
                    w_state_d = StRecv;
                end
            end
            StRecv: begin
                if (r_slot == LastSlot) begin
                    w_close = 1'b1;
                    // A fully empty group ends the burst; realign on the next valid.
                    if (!w_any_valid) begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Slot capture, group close and output registers.
    always_ff @(posedge cclk) begin
        if (reset) begin
            r_slot      <= '0;
            r_shadow_v  <= '0;
            r_valid_out <= '0;
            r_out_stb   <= 1'b0;
            r_group_cnt <= 8'h00;
            for (int i = 0; i < LANES - 1; i++) begin
                r_shadow_d[i] <= '0;
            end
            for (int i = 0; i < LANES; i++) begin
                r_data_out[i] <= '0;
            end
        end else begin
            r_out_stb <= 1'b0;
            if (r_state == StIdle) begin
                if (valid_in) begin
                    r_shadow_d[0] <= data_in;
                    r_shadow_v[0] <= 1'b1;
                    r_slot        <= SW'(1);
                end
            end else if (w_close) begin
                for (int i = 0; i < LANES - 1; i++) begin
                    r_data_out[i]  <= r_shadow_d[i];
                    r_valid_out[i] <= r_shadow_v[i];
                end
                r_data_out[LANES-1]  <= w_byte;
                r_valid_out[LANES-1] <= valid_in;
                r_out_stb            <= 1'b1;
                r_group_cnt          <= r_group_cnt + 8'd1;
                r_slot               <= '0;
            end else begin
                // Transmitter walks one lane per cycle, so capture regardless of valid.
                for (int i = 0; i < LANES - 1; i++) begin
                    if (r_slot == SW'(i)) begin
                        r_shadow_d[i] <= w_byte;
                        r_shadow_v[i] <= valid_in;
                    end
                end
                r_slot <= r_slot + SW'(1);
            end
        end
    end

    assign data_out0  = r_data_out[0];
    assign data_out1  = r_data_out[1];
    assign data_out2  = r_data_out[2];
    assign data_out3  = r_data_out[3];
    assign valid_out0 = r_valid_out[0];
    assign valid_out1 = r_valid_out[1];
    assign valid_out2 = r_valid_out[2];
    assign valid_out3 = r_valid_out[3];
    assign out_stb    = r_out_stb;
    assign group_cnt  = r_group_cnt;

endmodule

// File: tb/tb_demux_l2_rx.sv
// Directed bench for demux_l2_rx with hand-computed expected values.
module tb_demux_l2_rx;

    logic       cclk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [7:0] data_in;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic       out_stb;
    logic [7:0] group_cnt;

    int checks = 0;
    int errors = 0;

    demux_l2_rx dut (
        .cclk       (cclk),
        .reset      (reset),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .data_out0  (data_out0),
        .data_out1  (data_out1),
        .data_out2  (data_out2),
        .data_out3  (data_out3),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .valid_out2 (valid_out2),
        .valid_out3 (valid_out3),
        .out_stb    (out_stb),
        .group_cnt  (group_cnt)
    );

    always #5 cclk = ~cclk;

    logic [31:0] w_data;
    logic [3:0]  w_valid;
    assign w_data  = {data_out0, data_out1, data_out2, data_out3};
    assign w_valid = {valid_out0, valid_out1, valid_out2, valid_out3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one byte, let one edge pass, then settle before sampling.
    task automatic send(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge cclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        send(1'b0, 8'h00);
        send(1'b0, 8'h00);
        reset = 1'b0;
    endtask

    task automatic chk_group(input string tag, input logic [31:0] d, input logic [3:0] v,
                             input logic [7:0] cnt);
        chk({tag, "_stb"}, {31'd0, out_stb}, 32'd1);
        chk({tag, "_data"}, w_data, d);
        chk({tag, "_valid"}, {28'd0, w_valid}, {28'd0, v});
        chk({tag, "_cnt"}, {24'd0, group_cnt}, {24'd0, cnt});
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        do_reset();
        chk("rst_data", w_data, 32'h0);
        chk("rst_valid", {28'd0, w_valid}, 32'h0);
        chk("rst_stb", {31'd0, out_stb}, 32'd0);
        chk("rst_cnt", {24'd0, group_cnt}, 32'd0);

        // 1. Basic group
        send(1'b1, 8'hFF);
        chk("t1_stb_a", {31'd0, out_stb}, 32'd0);
        send(1'b1, 8'hEE);
        send(1'b1, 8'hDD);
        chk("t1_stb_b", {31'd0, out_stb}, 32'd0);
        send(1'b1, 8'hCC);
        chk_group("t1", 32'hFFEEDDCC, 4'b1111, 8'd1);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 8'h00);
            chk("t1_stb_once", {31'd0, out_stb}, 32'd0);
            chk("t1_hold", w_data, 32'hFFEEDDCC);
        end

        // 2. Back-to-back groups
        do_reset();
        send(1'b1, 8'hFF);
        send(1'b1, 8'hEE);
        send(1'b1, 8'hDD);
        send(1'b1, 8'hCC);
        chk_group("t2a", 32'hFFEEDDCC, 4'b1111, 8'd1);
        send(1'b1, 8'hBB);
        chk("t2_gap1", {31'd0, out_stb}, 32'd0);
        send(1'b1, 8'hAA);
        chk("t2_gap2", {31'd0, out_stb}, 32'd0);
        send(1'b1, 8'h99);
        chk("t2_gap3", {31'd0, out_stb}, 32'd0);
        send(1'b1, 8'h88);
        chk_group("t2b", 32'hBBAA9988, 4'b1111, 8'd2);

        // 3. Partial group (invalid bytes carry junk that must be zeroed)
        send(1'b0, 8'h12);
        send(1'b0, 8'h34);
        send(1'b1, 8'h77);
        send(1'b0, 8'h56);
        chk_group("t3p", 32'h00007700, 4'b0010, 8'd3);
        send(1'b0, 8'h5A);
        send(1'b0, 8'h5A);
        send(1'b0, 8'h5A);
        send(1'b0, 8'h5A);
        chk_group("t3e", 32'h00000000, 4'b0000, 8'd4);
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 8'h00);
            chk("t3_idle_stb", {31'd0, out_stb}, 32'd0);
        end
        // Realignment from an arbitrary cycle proves the block is back in idle at slot 0.
        send(1'b1, 8'hA1);
        send(1'b1, 8'hA2);
        send(1'b1, 8'hA3);
        chk("t3_realign_stb", {31'd0, out_stb}, 32'd0);
        send(1'b1, 8'hA4);
        chk_group("t3r", 32'hA1A2A3A4, 4'b1111, 8'd5);

        // 4. Idle alignment
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send(1'b0, 8'h00);
            chk("t4_idle_stb", {31'd0, out_stb}, 32'd0);
        end
        send(1'b1, 8'h11);
        send(1'b1, 8'h22);
        send(1'b1, 8'h33);
        send(1'b1, 8'h44);
        chk_group("t4", 32'h11223344, 4'b1111, 8'd1);

        // 5. Reset mid-group (on the third byte)
        send(1'b1, 8'h11);
        send(1'b1, 8'h22);
        reset = 1'b1;
        send(1'b1, 8'h33);
        reset = 1'b0;
        chk("t5_stb", {31'd0, out_stb}, 32'd0);
        chk("t5_data", w_data, 32'h0);
        chk("t5_valid", {28'd0, w_valid}, 32'h0);
        chk("t5_cnt", {24'd0, group_cnt}, 32'd0);
        send(1'b0, 8'h00);
        send(1'b1, 8'h55);
        send(1'b1, 8'h66);
        send(1'b1, 8'h77);
        send(1'b1, 8'h88);
        chk_group("t5", 32'h55667788, 4'b1111, 8'd1);

        // Reset wins over a group close on the same edge.
        send(1'b1, 8'h01);
        send(1'b1, 8'h02);
        send(1'b1, 8'h03);
        reset = 1'b1;
        send(1'b1, 8'h04);
        reset = 1'b0;
        chk("t5p_stb", {31'd0, out_stb}, 32'd0);
        chk("t5p_data", w_data, 32'h0);
        chk("t5p_cnt", {24'd0, group_cnt}, 32'd0);

        // 6. Counter wrap over 256 back-to-back groups
        do_reset();
        for (int g = 0; g < 256; g++) begin
            for (int s = 0; s < 4; s++) begin
                send(1'b1, 8'((g * 4 + s) & 8'hFF));
                if (s == 3) begin
                    chk("t6_stb_hi", {31'd0, out_stb}, 32'd1);
                    chk("t6_cnt", {24'd0, group_cnt}, {24'd0, 8'((g + 1) & 8'hFF)});
                end else begin
                    chk("t6_stb_lo", {31'd0, out_stb}, 32'd0);
                end
            end
        end
        chk("t6_wrap", {24'd0, group_cnt}, 32'd0);
        chk("t6_last_data", w_data, 32'hFCFDFEFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
